joy_db15_tx: RTL and testbench

Device-side end of the serial DB15 joystick link: it emulates the two-player parallel-to-serial adapter that the core's DB15 reader polls over the user port. It latches two joystick words while the host holds JOY_LOAD low, then shifts them out one bit per host JOY_CLK rising edge on JOY_DATA. It is used in loopback benches and in adapter-side FPGA builds, driven from the system clock domain, with all host lines treated as asynchronous.

---
 rtl/joy_db15_pkg.sv | 32 +++
 rtl/joy_db15_tx_sync_filter.sv | 55 +++++
 rtl/joy_db15_tx.sv | 140 ++++++++++++++
 tb/tb_joy_db15_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 serial joystick link (reader and device side).
package joy_db15_pkg;

    localparam int unsigned FRAME_BITS   = 32;
    localparam int unsigned PLAYER_BITS  = 16;
    localparam int unsigned BIT_CNT_BITS = $clog2(FRAME_BITS);
    localparam int unsigned WD_BITS      = 24;

    // Position of each player's bit 0 within the serial frame.
    localparam int unsigned P1_BASE = 0;
    localparam int unsigned P2_BASE = PLAYER_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [FRAME_BITS-1:0] frame_t;

    // Assemble the frame so that bit 0 goes out first.
    function automatic frame_t build_frame(input logic [PLAYER_BITS-1:0] p1,
                                           input logic [PLAYER_BITS-1:0] p2);
        frame_t f;
        f = '1;
        f[P1_BASE +: PLAYER_BITS] = p1;
        f[P2_BASE +: PLAYER_BITS] = p2;
        return f;
    endfunction

endpackage

// File: rtl/joy_db15_tx_sync_filter.sv
// Synchroniser plus stability filter for one asynchronous host line.
module sync_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER      = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Metastability chain; idles high like the host lines.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Accept a new level only after FILTER consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync_out == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                level <= sync_out;
                rise  <= sync_out;
                fall  <= ~sync_out;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/joy_db15_tx.sv
// Device side of the serial DB15 joystick link: latch two players, shift out on host clock.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int unsigned         SYNC_STAGES = 2,
    parameter int unsigned         FILTER      = 3,
    parameter logic [WD_BITS-1:0]  TIMEOUT     = 24'd4_000_000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   JOY_CLK,
    input  logic                   JOY_LOAD,
    output logic                   JOY_DATA,
    input  logic [PLAYER_BITS-1:0] joystick1,
    input  logic [PLAYER_BITS-1:0] joystick2,
    output logic                   frame_done,
    output logic                   overrun,
    output logic                   link_idle
);

    localparam logic [BIT_CNT_BITS-1:0] LAST_BIT = BIT_CNT_BITS'(FRAME_BITS - 1);

    logic clk_lvl, clk_rise, clk_fall;
    logic load_lvl, load_rise, load_fall;

    state_t                  state_q, state_d;
    frame_t                  shreg_q, shreg_d;
    frame_t                  frame;
    logic [BIT_CNT_BITS-1:0] cnt_q, cnt_d;
    logic [WD_BITS-1:0]      wd_q, wd_d;
    logic                    data_d, done_d, overrun_d, idle_d;
    logic                    unused_ok;

    sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER)) u_clk_filt (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (JOY_CLK),
        .level   (clk_lvl),
        .rise    (clk_rise),
        .fall    (clk_fall)
    );

    sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER)) u_load_filt (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (JOY_LOAD),
        .level   (load_lvl),
        .rise    (load_rise),
        .fall    (load_fall)
    );

    // Shifting happens on the rising edge only.
    assign unused_ok = &{1'b1, clk_lvl, clk_fall};

    assign frame = build_frame(joystick1, joystick2);

    // State, shift register, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shreg_q    <= '1;
            cnt_q      <= '0;
            wd_q       <= TIMEOUT;
            JOY_DATA   <= 1'b1;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            link_idle  <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            JOY_DATA   <= data_d;
            frame_done <= done_d;
            overrun    <= overrun_d;
            link_idle  <= idle_d;
        end
    end

    // Next-state, datapath and output decode; a load fall overrides everything.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        data_d    = JOY_DATA;
        done_d    = 1'b0;
        overrun_d = overrun;
        wd_d      = (wd_q == TIMEOUT) ? wd_q : wd_q + WD_BITS'(1);

        if (load_fall) begin
            state_d   = LOAD;
            shreg_d   = frame;
            cnt_d     = '0;
            data_d    = ~frame[0];
            overrun_d = 1'b0;
            wd_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    data_d = 1'b1;
                end
                LOAD: begin
                    // Keep tracking the inputs; the rise cycle captures the frame.
                    shreg_d = frame;
                    cnt_d   = '0;
                    data_d  = ~frame[0];
                    if (load_rise || load_lvl) begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (clk_rise) begin
                        shreg_d = {1'b1, shreg_q[FRAME_BITS-1:1]};
                        if (cnt_q == LAST_BIT) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            data_d  = 1'b1;
                        end else begin
                            cnt_d  = cnt_q + BIT_CNT_BITS'(1);
                            data_d = ~shreg_q[1];
                        end
                    end
                end
                DONE: begin
                    data_d = 1'b1;
                    if (clk_rise) begin
                        overrun_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    data_d  = 1'b1;
                end
            endcase
        end

        idle_d = (wd_d == TIMEOUT);
    end

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed scoreboard bench for joy_db15_tx acting as a host poller.
module tb_joy_db15_tx;

    localparam int unsigned  H       = 10;      // host half-period in clk cycles
    localparam logic [23:0]  TIMEOUT = 24'd2000;

    logic        clk;
    logic        reset_n;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic        JOY_DATA;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        frame_done;
    logic        overrun;
    logic        link_idle;

    int   vectors     = 0;
    int   miscompares = 0;
    int   done_cnt    = 0;
    int   done_bad    = 0;
    int   d0;
    logic exp_q[$];
    logic peek;

    joy_db15_tx #(.SYNC_STAGES(2), .FILTER(3), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .JOY_CLK    (JOY_CLK),
        .JOY_LOAD   (JOY_LOAD),
        .JOY_DATA   (JOY_DATA),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .frame_done (frame_done),
        .overrun    (overrun),
        .link_idle  (link_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_done pulses and confirm the wire is released in the same cycle.
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            done_cnt++;
            if (JOY_DATA !== 1'b1) done_bad++;
        end
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "bench timeout");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] a, input logic [15:0] b, input int extra);
        for (int i = 0; i < 16; i++) exp_q.push_back(~a[i]);
        for (int i = 0; i < 16; i++) exp_q.push_back(~b[i]);
        for (int i = 0; i < extra; i++) exp_q.push_back(1'b1);
    endtask

    task automatic load_low();
        JOY_LOAD = 1'b0;
        cycles(H);
    endtask

    task automatic load_high();
        JOY_LOAD = 1'b1;
        cycles(H);
    endtask

    // Sample the current bit, then give one host clock pulse (idle high, rise shifts).
    task automatic read_bits(input int n);
        logic e;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL scoreboard_empty: observed no entry expected one at read %0d", i);
            end else begin
                e = exp_q.pop_front();
                check("wire_bit", {31'b0, JOY_DATA}, {31'b0, e});
            end
            JOY_CLK = 1'b0;
            cycles(H);
            JOY_CLK = 1'b1;
            cycles(H);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        JOY_CLK   = 1'b1;
        JOY_LOAD  = 1'b1;
        joystick1 = 16'h0000;
        joystick2 = 16'h0000;
        cycles(3);

        // Reset state
        check("rst_data",    {31'b0, JOY_DATA},   32'd1);
        check("rst_done",    {31'b0, frame_done}, 32'd0);
        check("rst_overrun", {31'b0, overrun},    32'd0);
        check("rst_idle",    {31'b0, link_idle},  32'd1);
        reset_n = 1'b1;
        cycles(5);
        check("idle_data", {31'b0, JOY_DATA}, 32'd1);

        // Full frame 0001/8000; watchdog clears soon after the load falls
        joystick1 = 16'h0001;
        joystick2 = 16'h8000;
        push_frame(joystick1, joystick2, 0);
        JOY_LOAD = 1'b0;
        cycles(7);
        check("idle_clear", {31'b0, link_idle}, 32'd0);
        cycles(H - 7);
        load_high();
        d0 = done_cnt;
        read_bits(32);
        check("fill_after_frame", {31'b0, JOY_DATA}, 32'd1);
        check("done_once",        done_cnt - d0,     32'd1);
        check("no_overrun",       {31'b0, overrun},  32'd0);

        // Same frame with three extra clocks
        push_frame(joystick1, joystick2, 3);
        load_low();
        load_high();
        read_bits(35);
        check("overrun_set", {31'b0, overrun}, 32'd1);

        // Abort after 10 bits; the next load also clears overrun
        joystick1 = 16'h1234;
        joystick2 = 16'hFEDC;
        push_frame(joystick1, joystick2, 0);
        load_low();
        check("overrun_clear", {31'b0, overrun}, 32'd0);
        load_high();
        read_bits(10);
        d0 = done_cnt;
        exp_q.delete();
        joystick1 = 16'h00F0;
        joystick2 = 16'h0F0F;
        push_frame(joystick1, joystick2, 0);
        load_low();
        load_high();
        check("abort_no_done", done_cnt - d0, 32'd0);
        read_bits(32);
        check("restart_done", done_cnt - d0, 32'd1);

        // Short glitch on JOY_CLK and inputs changed mid-frame
        joystick1 = 16'hA5C3;
        joystick2 = 16'h3C5A;
        push_frame(joystick1, joystick2, 0);
        load_low();
        load_high();
        read_bits(5);
        JOY_CLK = 1'b0;
        cycles(2);
        JOY_CLK = 1'b1;
        cycles(12);
        peek = exp_q[0];
        check("glitch_no_shift", {31'b0, JOY_DATA}, {31'b0, peek});
        joystick1 = ~joystick1;
        joystick2 = ~joystick2;
        read_bits(27);

        // Reset mid-frame releases the wire at once
        joystick1 = 16'hFFFF;
        joystick2 = 16'hFFFF;
        push_frame(joystick1, joystick2, 0);
        load_low();
        load_high();
        read_bits(3);
        check("pre_reset_data", {31'b0, JOY_DATA}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("reset_async_data", {31'b0, JOY_DATA},  32'd1);
        check("reset_async_idle", {31'b0, link_idle}, 32'd1);
        exp_q.delete();
        cycles(2);
        reset_n = 1'b1;
        cycles(20);
        check("post_reset_wait", {31'b0, JOY_DATA}, 32'd1);

        // Watchdog: saturated after TIMEOUT quiet cycles, cleared by a load
        cycles(int'(TIMEOUT) + 20);
        check("watchdog_idle", {31'b0, link_idle}, 32'd1);
        joystick1 = 16'h8421;
        joystick2 = 16'h1248;
        push_frame(joystick1, joystick2, 0);
        JOY_LOAD = 1'b0;
        cycles(7);
        check("watchdog_clear", {31'b0, link_idle}, 32'd0);
        cycles(H - 7);
        load_high();
        read_bits(32);

        check("done_with_fill", done_bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
